uart_frame_ctrl: RTL and testbench

//  Sequences the UART byte receiver: consumes its Rx_Done/Data_Byte strobes, parses framed packets
//  (HDR, CMD, LEN, payload, XOR checksum), and buffers each payload until its checksum passes.

---
 rtl/uart_frame_ctrl_if.sv | 40 ++++
 rtl/uart_frame_ctrl.sv | 201 ++++++++++++++++++++
 tb/tb_uart_frame_ctrl.sv | 306 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_frame_ctrl_if.sv
// Bundle between the UART byte receiver, the frame controller and the
// downstream payload consumer.
//
// Handshakes:
//   Rx_Done/Data_Byte : one-cycle strobe from the receiver, no back-pressure.
//                       Data_Byte is only meaningful while Rx_Done is high.
//   Frm_Valid/Frm_Ready: a payload byte moves on every rising Clk edge where
//                       Frm_Valid && Frm_Ready. Once Frm_Valid rises, it and
//                       Frm_Data/Frm_Last hold steady until that transfer.
//                       Frm_Ready may change freely and never gates Frm_Valid.
interface uart_frame_ctrl_if;
  logic        Rx_Done;
  logic [7:0]  Data_Byte;
  logic [15:0] bps_SET;
  logic [7:0]  Frm_Data;
  logic        Frm_Valid;
  logic        Frm_Last;
  logic        Frm_Ready;
  logic        Busy;
  logic        Err_Chk;
  logic        Err_Len;
  logic        Err_Cmd;
  logic        Err_Tout;
  logic        Overrun;
  logic [2:0]  Dbg_State;

  // Controller side
  modport master (
    input  Rx_Done, Data_Byte, Frm_Ready,
    output bps_SET, Frm_Data, Frm_Valid, Frm_Last, Busy,
    output Err_Chk, Err_Len, Err_Cmd, Err_Tout, Overrun, Dbg_State
  );

  // Receiver / consumer side
  modport slave (
    output Rx_Done, Data_Byte, Frm_Ready,
    input  bps_SET, Frm_Data, Frm_Valid, Frm_Last, Busy,
    input  Err_Chk, Err_Len, Err_Cmd, Err_Tout, Overrun, Dbg_State
  );
endinterface

// File: rtl/uart_frame_ctrl.sv
// UART frame controller: parses HDR/CMD/LEN/payload/CHK frames from the
// receiver's byte strobes, buffers the payload until the XOR checksum
// passes, replays good data frames on a valid/ready stream and applies
// baud-set frames to bps_SET.
module uart_frame_ctrl #(
  parameter int          MAX_LEN     = 16,
  parameter int          TIMEOUT_CYC = 50000,
  parameter logic [7:0]  HDR         = 8'hAA,
  parameter logic [15:0] BPS_RST     = 16'd4
) (
  input logic               Clk,
  input logic               Rst,
  uart_frame_ctrl_if.master bus
);
  localparam int PTR_W = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int TW    = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

  localparam logic [7:0]    CMD_DATA  = 8'h01;
  localparam logic [7:0]    CMD_BAUD  = 8'h02;
  localparam logic [7:0]    MAX_LEN_B = 8'(MAX_LEN);
  localparam logic [TW-1:0] TOUT_LAST = TW'(TIMEOUT_CYC - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CMD   = 3'd1,
    S_LEN   = 3'd2,
    S_PAY   = 3'd3,
    S_CHK   = 3'd4,
    S_DRAIN = 3'd5
  } state_t;

  state_t           state_q, state_d;
  logic [7:0]       cmd_q, cmd_d;
  logic [7:0]       len_q, len_d;
  logic [7:0]       chk_q, chk_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [TW-1:0]    tout_q, tout_d;
  logic [15:0]      bps_q, bps_d;
  logic             err_chk_q, err_chk_d;
  logic             err_len_q, err_len_d;
  logic             err_cmd_q, err_cmd_d;
  logic             err_tout_q, err_tout_d;
  logic             ovr_q, ovr_d;
  logic             buf_we;
  logic [7:0]       buf_q [MAX_LEN];

  logic       rx;
  logic [7:0] byte_in;
  logic       drain_last;

  assign rx         = bus.Rx_Done;
  assign byte_in    = bus.Data_Byte;
  assign drain_last = (8'(rd_ptr_q) == (len_q - 8'd1));

  // Output decode: the stream is live for the whole of DRAIN
  assign bus.Frm_Valid = (state_q == S_DRAIN);
  assign bus.Frm_Data  = (state_q == S_DRAIN) ? buf_q[rd_ptr_q] : 8'h00;
  assign bus.Frm_Last  = (state_q == S_DRAIN) && drain_last;
  assign bus.Busy      = (state_q != S_IDLE);
  assign bus.bps_SET   = bps_q;
  assign bus.Err_Chk   = err_chk_q;
  assign bus.Err_Len   = err_len_q;
  assign bus.Err_Cmd   = err_cmd_q;
  assign bus.Err_Tout  = err_tout_q;
  assign bus.Overrun   = ovr_q;
  assign bus.Dbg_State = state_q;

  // Next-state, datapath and error-pulse decode
  always_comb begin
    state_d    = state_q;
    cmd_d      = cmd_q;
    len_d      = len_q;
    chk_d      = chk_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    tout_d     = tout_q;
    bps_d      = bps_q;
    err_chk_d  = 1'b0;
    err_len_d  = 1'b0;
    err_cmd_d  = 1'b0;
    err_tout_d = 1'b0;
    ovr_d      = 1'b0;
    buf_we     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (rx && byte_in == HDR) state_d = S_CMD;
      end
      S_CMD: begin
        if (rx) begin
          cmd_d   = byte_in;
          chk_d   = byte_in;
          state_d = S_LEN;
        end
      end
      S_LEN: begin
        if (rx) begin
          len_d    = byte_in;
          chk_d    = chk_q ^ byte_in;
          wr_ptr_d = '0;
          if (byte_in > MAX_LEN_B) begin
            err_len_d = 1'b1;
            state_d   = S_IDLE;
          end else if (byte_in == 8'd0) begin
            state_d = S_CHK;
          end else begin
            state_d = S_PAY;
          end
        end
      end
      S_PAY: begin
        if (rx) begin
          buf_we = 1'b1;
          chk_d  = chk_q ^ byte_in;
          if (8'(wr_ptr_q) == (len_q - 8'd1)) state_d = S_CHK;
          else wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
      end
      S_CHK: begin
        if (rx) begin
          state_d = S_IDLE;
          if (byte_in != chk_q) begin
            err_chk_d = 1'b1;
          end else if (cmd_q == CMD_DATA) begin
            if (len_q != 8'd0) begin
              state_d  = S_DRAIN;
              rd_ptr_d = '0;
            end
          end else if (cmd_q == CMD_BAUD && len_q == 8'd1 && buf_q[0] <= 8'd4) begin
            bps_d = {8'h00, buf_q[0]};
          end else begin
            err_cmd_d = 1'b1;
          end
        end
      end
      S_DRAIN: begin
        // Receiver cannot be stalled, so bytes arriving now are lost
        if (rx) ovr_d = 1'b1;
        if (bus.Frm_Ready) begin
          if (drain_last) state_d = S_IDLE;
          else rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Inter-byte watchdog, only while a frame is open
    if (state_q inside {S_CMD, S_LEN, S_PAY, S_CHK}) begin
      if (rx) begin
        tout_d = '0;
      end else if (tout_q == TOUT_LAST) begin
        tout_d     = '0;
        err_tout_d = 1'b1;
        state_d    = S_IDLE;
      end else begin
        tout_d = tout_q + TW'(1);
      end
    end else begin
      tout_d = '0;
    end
  end

  // Control and status registers
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q    <= S_IDLE;
      cmd_q      <= '0;
      len_q      <= '0;
      chk_q      <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      tout_q     <= '0;
      bps_q      <= BPS_RST;
      err_chk_q  <= 1'b0;
      err_len_q  <= 1'b0;
      err_cmd_q  <= 1'b0;
      err_tout_q <= 1'b0;
      ovr_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cmd_q      <= cmd_d;
      len_q      <= len_d;
      chk_q      <= chk_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      tout_q     <= tout_d;
      bps_q      <= bps_d;
      err_chk_q  <= err_chk_d;
      err_len_q  <= err_len_d;
      err_cmd_q  <= err_cmd_d;
      err_tout_q <= err_tout_d;
      ovr_q      <= ovr_d;
    end
  end

  // Payload buffer; contents are only read after a full frame rewrites them
  always_ff @(posedge Clk) begin
    if (buf_we) buf_q[wr_ptr_q] <= byte_in;
  end
endmodule

// File: tb/tb_uart_frame_ctrl.sv
// Bench for uart_frame_ctrl: directed frames, a frame-level model with an
// expected payload queue, a per-cycle compare process and literal checks.
module tb_uart_frame_ctrl;
  localparam int          MAX_LEN = 16;
  localparam int          TOUT    = 40;
  localparam logic [7:0]  HDR     = 8'hAA;
  localparam logic [15:0] BPS_RST = 16'd4;

  logic Clk;
  logic Rst;

  uart_frame_ctrl_if bus ();

  uart_frame_ctrl #(
    .MAX_LEN(MAX_LEN), .TIMEOUT_CYC(TOUT), .HDR(HDR), .BPS_RST(BPS_RST)
  ) dut (
    .Clk(Clk),
    .Rst(Rst),
    .bus(bus)
  );

  // ---------------- clock / reset ----------------
  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // ---------------- scoreboard state ----------------
  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  logic chk_en = 1'b0;

  logic [7:0]  exp_q[$];   // payload bytes still owed on the stream
  logic [7:0]  fq[$];      // bytes of the open frame after HDR
  logic [7:0]  log_q[$];   // bytes accepted from the DUT
  int          last_cnt;
  logic        last_on_final;
  logic        open_m;
  logic        hs_pending;
  int          silent;
  logic [15:0] bps_m;
  int due_chk  = -1;
  int due_len  = -1;
  int due_cmd  = -1;
  int due_tout = -1;
  int due_ovr  = -1;
  int n_chk_seen = 0, n_len_seen = 0, n_cmd_seen = 0, n_tout_seen = 0, n_ovr_seen = 0;

  int   ready_mode = 0;
  int   rcnt = 0;
  logic prev_vld, prev_rdy, prev_last;
  logic [7:0] prev_data;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- frame-level model ----------------
  task automatic frame_step();
    int n;
    logic [7:0] x;
    n = fq.size();
    if (n == 2 && fq[1] > 8'(MAX_LEN)) begin
      due_len = cyc;
      open_m  = 1'b0;
    end else if (n >= 2 && n == int'(fq[1]) + 3) begin
      x = 8'h00;
      for (int i = 0; i < n - 1; i++) x = x ^ fq[i];
      if (x != fq[n-1]) due_chk = cyc;
      else if (fq[0] == 8'h01) begin
        for (int i = 2; i < n - 1; i++) exp_q.push_back(fq[i]);
      end else if (fq[0] == 8'h02 && fq[1] == 8'd1 && fq[2] <= 8'd4) bps_m = {8'h00, fq[2]};
      else due_cmd = cyc;
      open_m = 1'b0;
    end
  endtask

  always @(posedge Clk) begin
    logic draining;
    cyc++;
    if (Rst) begin
      open_m = 1'b0; fq.delete(); exp_q.delete(); bps_m = BPS_RST;
      silent = 0; hs_pending = 1'b0;
    end else begin
      draining   = (exp_q.size() > 0) || hs_pending;
      hs_pending = 1'b0;
      if (bus.Rx_Done) begin
        if (draining) due_ovr = cyc;
        else if (!open_m) begin
          if (bus.Data_Byte == HDR) begin open_m = 1'b1; fq.delete(); silent = 0; end
        end else begin
          silent = 0;
          fq.push_back(bus.Data_Byte);
          frame_step();
        end
      end else if (open_m) begin
        silent++;
        if (silent == TOUT) begin due_tout = cyc; open_m = 1'b0; end
      end
    end
  end

  // ---------------- compare process ----------------
  always @(negedge Clk) begin
    if (chk_en) begin
      check("busy",     bus.Busy,      open_m || (exp_q.size() > 0));
      check("bps_set",  bus.bps_SET,   bps_m);
      check("err_chk",  bus.Err_Chk,   due_chk  == cyc);
      check("err_len",  bus.Err_Len,   due_len  == cyc);
      check("err_cmd",  bus.Err_Cmd,   due_cmd  == cyc);
      check("err_tout", bus.Err_Tout,  due_tout == cyc);
      check("overrun",  bus.Overrun,   due_ovr  == cyc);
      check("frm_valid", bus.Frm_Valid, exp_q.size() > 0);
      if (bus.Frm_Valid && prev_vld && !prev_rdy) begin
        check("stall_data", bus.Frm_Data, prev_data);
        check("stall_last", bus.Frm_Last, prev_last);
      end
      if (bus.Frm_Valid && exp_q.size() > 0) begin
        check("frm_data", bus.Frm_Data, exp_q[0]);
        check("frm_last", bus.Frm_Last, exp_q.size() == 1);
        if (bus.Frm_Ready) begin
          log_q.push_back(bus.Frm_Data);
          if (bus.Frm_Last) last_cnt++;
          last_on_final = bus.Frm_Last;
          void'(exp_q.pop_front());
          hs_pending = 1'b1;
        end
      end
      if (bus.Err_Chk)  n_chk_seen++;
      if (bus.Err_Len)  n_len_seen++;
      if (bus.Err_Cmd)  n_cmd_seen++;
      if (bus.Err_Tout) n_tout_seen++;
      if (bus.Overrun)  n_ovr_seen++;
    end
    prev_vld  = bus.Frm_Valid;
    prev_rdy  = bus.Frm_Ready;
    prev_data = bus.Frm_Data;
    prev_last = bus.Frm_Last;
  end

  // ---------------- driver tasks ----------------
  always @(posedge Clk) begin
    #2;
    case (ready_mode)
      0: bus.Frm_Ready = 1'b1;
      1: bus.Frm_Ready = (rcnt % 3 == 0);
      default: bus.Frm_Ready = 1'b0;
    endcase
    rcnt++;
  end

  task automatic send_byte(input logic [7:0] b);
    @(posedge Clk); #2;
    bus.Rx_Done = 1'b1; bus.Data_Byte = b;
    @(posedge Clk); #2;
    bus.Rx_Done = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] b[$]);
    foreach (b[i]) send_byte(b[i]);
  endtask

  task automatic wait_idle(input string name);
    int k;
    k = 0;
    while ((bus.Busy || exp_q.size() > 0) && k < 300) begin
      @(posedge Clk); #2;
      k++;
    end
    check(name, k < 300, 1'b1);
    repeat (2) @(posedge Clk);
    #2;
  endtask

  task automatic clear_log();
    log_q.delete(); last_cnt = 0; last_on_final = 1'b0;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_bps"},   bus.bps_SET,   BPS_RST);
    check({tag, "_data"},  bus.Frm_Data,  8'h00);
    check({tag, "_valid"}, bus.Frm_Valid, 1'b0);
    check({tag, "_last"},  bus.Frm_Last,  1'b0);
    check({tag, "_busy"},  bus.Busy,      1'b0);
    check({tag, "_pulses"}, {bus.Err_Chk, bus.Err_Len, bus.Err_Cmd, bus.Err_Tout, bus.Overrun}, 5'b0);
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    Rst = 1'b1;
    bus.Rx_Done = 1'b0;
    bus.Data_Byte = 8'h00;
    bus.Frm_Ready = 1'b1;
    clear_log();
    repeat (3) @(posedge Clk);
    @(negedge Clk);
    check_reset_values("reset");
    @(posedge Clk); #2;
    Rst = 1'b0;
    chk_en = 1'b1;

    // 1: stray byte in IDLE, then a plain data frame with ready always high
    send_byte(8'h55);
    clear_log();
    send_frame('{8'hAA, 8'h01, 8'h03, 8'h11, 8'h22, 8'h33, 8'h02});
    wait_idle("t1_idle");
    check("t1_count", log_q.size(), 3);
    check("t1_bytes", {log_q[0], log_q[1], log_q[2]}, 24'h112233);
    check("t1_last_cnt", last_cnt, 1);
    check("t1_last_final", last_on_final, 1'b1);

    // 1b: header value inside the payload is ordinary data
    clear_log();
    send_frame('{8'hAA, 8'h01, 8'h02, 8'hAA, 8'h55, 8'hFC});
    wait_idle("t1b_idle");
    check("t1b_bytes", {log_q[0], log_q[1]}, 16'hAA55);

    // 2: same frame with ready high one cycle in three
    ready_mode = 1;
    clear_log();
    send_frame('{8'hAA, 8'h01, 8'h03, 8'h11, 8'h22, 8'h33, 8'h02});
    wait_idle("t2_idle");
    check("t2_count", log_q.size(), 3);
    check("t2_bytes", {log_q[0], log_q[1], log_q[2]}, 24'h112233);
    ready_mode = 0;

    // 3: baud set to 2, then an out-of-range index
    send_frame('{8'hAA, 8'h02, 8'h01, 8'h02, 8'h01});
    check("t3_bps_now", bus.bps_SET, 16'd2);
    send_frame('{8'hAA, 8'h02, 8'h01, 8'h07, 8'h04});
    repeat (2) @(posedge Clk);
    #2;
    check("t3_err_cmd_cnt", n_cmd_seen, 1);
    check("t3_bps_kept", bus.bps_SET, 16'd2);

    // 4: bad checksum, then oversize length
    clear_log();
    send_frame('{8'hAA, 8'h01, 8'h02, 8'h10, 8'h20, 8'h34});
    repeat (3) @(posedge Clk);
    #2;
    check("t4_err_chk_cnt", n_chk_seen, 1);
    check("t4_no_stream", log_q.size(), 0);
    send_frame('{8'hAA, 8'h01, 8'h11});
    repeat (2) @(posedge Clk);
    #2;
    check("t4_err_len_cnt", n_len_seen, 1);
    check("t4_len_busy", bus.Busy, 1'b0);

    // 5: silence after CMD, then a good frame
    send_frame('{8'hAA, 8'h01});
    repeat (TOUT + 4) @(posedge Clk);
    #2;
    check("t5_tout_cnt", n_tout_seen, 1);
    check("t5_busy", bus.Busy, 1'b0);
    clear_log();
    send_frame('{8'hAA, 8'h01, 8'h01, 8'h5A, 8'h5A});
    wait_idle("t5_idle");
    check("t5_count", log_q.size(), 1);
    check("t5_byte", log_q[0], 8'h5A);

    // 6: byte during drain, then reset in the middle of a payload
    ready_mode = 2;
    clear_log();
    send_frame('{8'hAA, 8'h01, 8'h02, 8'hC1, 8'hC2, 8'h00});
    repeat (3) @(posedge Clk);
    send_byte(8'h77);
    repeat (2) @(posedge Clk);
    ready_mode = 0;
    wait_idle("t6_idle");
    check("t6_ovr_cnt", n_ovr_seen, 1);
    check("t6_bytes", {log_q[0], log_q[1]}, 16'hC1C2);

    send_frame('{8'hAA, 8'h01, 8'h04, 8'h01, 8'h02});
    check("t6_busy_pay", bus.Busy, 1'b1);
    Rst = 1'b1;
    @(posedge Clk); #2;
    Rst = 1'b0;
    check_reset_values("midrst");

    // zero-length data frame: accepted silently
    send_frame('{8'hAA, 8'h01, 8'h00, 8'h01});
    repeat (3) @(posedge Clk);
    #2;
    check("t7_busy", bus.Busy, 1'b0);
    check("t7_valid", bus.Frm_Valid, 1'b0);

    repeat (4) @(posedge Clk);
    check("tot_chk", n_chk_seen, 1);
    check("tot_cmd", n_cmd_seen, 1);
    check("tot_len", n_len_seen, 1);
    check("tot_tout", n_tout_seen, 1);
    check("tot_ovr", n_ovr_seen, 1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Hard stop if the flow above ever stalls
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion (cycle %0d)", cyc);
    $fatal(1, "bench did not complete");
  end
endmodule
